mor1kx_dcache_l15_transducer: RTL and testbench
===============================================

// Module: mor1kx_dcache_l15_transducer
// PURPOSE
//  Converts mor1kx data-port requests (one 32-bit load/store at a time) into L1.5 request packets, and returns L1.5 responses to the CPU.
//  Sits upstream of the icache/dcache L1.5 arbiter. Drives its dcache_transducer_l15_* inputs and consumes its dcache_l15_transducer_* outputs.
//  Single outstanding request. Unsolicited invalidations are acknowledged and dropped.
// PARAMETERS
//  ADDR_HI    8'h00  bits [39:32] of every L1.5 address
//  NC_BIT     31     cpu_adr_i bit that, when 1, marks a request noncacheable
// PORTS
//  clk                               in   1   clock
//  rst                               in   1   synchronous reset, active-high
//  cpu_req_i                         in   1   request valid; held stable until cpu_ack_o/cpu_err_o
//  cpu_we_i                          in   1   1=store 0=load
//  cpu_adr_i                         in   32  byte address
//  cpu_dat_i                         in   32  store data, big-endian
//  cpu_bsel_i                        in   4   byte select; bit3 = byte at offset 0
//  cpu_ack_o                         out  1   one-cycle completion pulse
//  cpu_err_o                         out  1   one-cycle error pulse
//  cpu_dat_o                         out  32  load data, valid with cpu_ack_o
//  dcache_transducer_l15_val         out  1   request valid
//  dcache_transducer_l15_rqtype      out  5   `LOAD_RQ / `STORE_RQ
//  dcache_transducer_l15_amo_op      out  4   always 0
//  dcache_transducer_l15_data        out  64  store data
//  dcache_transducer_l15_size        out  3   `MSG_DATA_SIZE_1B/2B/4B
//  dcache_transducer_l15_nc          out  1   noncacheable
//  dcache_transducer_l15_l1rplway    out  2   always 0
//  dcache_transducer_l15_address     out  40  {ADDR_HI, cpu_adr_i[31:2], byte offset}
//  dcache_transducer_l15_req_ack     out  1   response consumed
//  dcache_l15_transducer_header_ack  in   1   request accepted
//  dcache_l15_transducer_val         in   1   response valid
//  dcache_l15_transducer_returntype  in   4   response type
//  dcache_l15_transducer_error       in   2   nonzero = error
//  dcache_l15_transducer_data_0      in   64  response data
// BEHAVIOUR
//  FSM states: IDLE, REQ, WAIT, DONE. Reset puts the FSM in IDLE and drives every output to 0.
//  IDLE: on cpu_req_i, register the request fields and go to REQ. No CPU ack is issued in the same cycle.
//  REQ: dcache_transducer_l15_val=1 and all request fields are held stable.
//    When header_ack=1, drop val the next cycle and go to WAIT.
//  WAIT: on dcache_l15_transducer_val, pulse req_ack=1 for the same cycle, then act on returntype:
//    `LOAD_RET on a load, or `ST_ACK on a store: latch data, go to DONE.
//    `EVICT_REQ / invalidation: req_ack only, stay in WAIT.
//    Any other type: req_ack only, stay in WAIT.
//  DONE: pulse cpu_ack_o for one cycle, or cpu_err_o if error!=0, then return to IDLE.
//    Next request is accepted no earlier than the following cycle.
//  Latency: cpu_req_i to L1.5 val = 1 cycle. Response val to cpu_ack_o = 1 cycle.
//  Size and offset from bsel:
//    1111 -> 4B, offset 00
//    1100 -> 2B, offset 00
//    0011 -> 2B, offset 10
//    one-hot 1000/0100/0010/0001 -> 1B, offset 00/01/10/11
//    Any other bsel: no L1.5 request; DONE with cpu_err_o.
//  Store data: {cpu_dat_i, cpu_dat_i}, i.e. replicated to 64 bits.
//  Load data: cpu_adr_i[2]==0 ? data_0[63:32] : data_0[31:0].
//  nc = cpu_adr_i[NC_BIT].
//  cpu_req_i dropping mid-transaction is ignored; the transaction completes and the ack is still issued.
//  rst mid-transaction aborts to IDLE immediately. A late L1.5 response while in IDLE still gets req_ack and is discarded.
// CONFIGURATION
//  MOR1KX_L15_ENDIAN_SWAP_EN defined:
//    Store data is byte-reversed within each 32-bit word before replication.
//    Load data is byte-reversed after word select.
//    bsel-to-offset mapping is mirrored (bit0 = offset 0).
//  MOR1KX_L15_ENDIAN_SWAP_EN undefined: no swapping, mapping as above.
// TESTING
//  Load adr=0x00001004, bsel=1111; L1.5 returns `LOAD_RET, data_0=0x11223344_55667788
//    -> address 0x0000001004, size 4B, cpu_dat_o=0x55667788, one cpu_ack_o.
//  Store adr=0x80000002, bsel=0011, dat=0xAABBCCDD
//    -> rqtype `STORE_RQ, nc=1, size 2B, address 0x0080000002, data 0xAABBCCDDAABBCCDD.
//    `ST_ACK then produces cpu_ack_o.
//  header_ack withheld for 5 cycles
//    -> val and fields stable for all 5 cycles; val deasserts the cycle after header_ack.
//  `EVICT_REQ arrives in WAIT before `LOAD_RET
//    -> req_ack pulsed for each response; exactly one cpu_ack_o, carrying the LOAD_RET data.
//  Response with error=2'b01 -> cpu_err_o pulse and no cpu_ack_o.
//    Separately, bsel=0110 -> cpu_err_o and no L1.5 val.
//  rst asserted in WAIT -> all outputs 0 the next cycle.
//    A subsequent load completes normally.

Source files
------------

// File: rtl/mor1kx_dcache_l15_transducer_if.sv
// L1.5 request/response bus between the mor1kx dcache transducer (master) and the L1.5 arbiter
// (slave).
interface mor1kx_dcache_l15_transducer_if;
    logic        dcache_transducer_l15_val;
    logic [4:0]  dcache_transducer_l15_rqtype;
    logic [3:0]  dcache_transducer_l15_amo_op;
    logic [63:0] dcache_transducer_l15_data;
    logic [2:0]  dcache_transducer_l15_size;
    logic        dcache_transducer_l15_nc;
    logic [1:0]  dcache_transducer_l15_l1rplway;
    logic [39:0] dcache_transducer_l15_address;
    logic        dcache_transducer_l15_req_ack;
    logic        dcache_l15_transducer_header_ack;
    logic        dcache_l15_transducer_val;
    logic [3:0]  dcache_l15_transducer_returntype;
    logic [1:0]  dcache_l15_transducer_error;
    logic [63:0] dcache_l15_transducer_data_0;

    modport master (
        output dcache_transducer_l15_val, dcache_transducer_l15_rqtype,
               dcache_transducer_l15_amo_op, dcache_transducer_l15_data,
               dcache_transducer_l15_size, dcache_transducer_l15_nc,
               dcache_transducer_l15_l1rplway, dcache_transducer_l15_address,
               dcache_transducer_l15_req_ack,
        input  dcache_l15_transducer_header_ack, dcache_l15_transducer_val,
               dcache_l15_transducer_returntype, dcache_l15_transducer_error,
               dcache_l15_transducer_data_0
    );

    modport slave (
        input  dcache_transducer_l15_val, dcache_transducer_l15_rqtype,
               dcache_transducer_l15_amo_op, dcache_transducer_l15_data,
               dcache_transducer_l15_size, dcache_transducer_l15_nc,
               dcache_transducer_l15_l1rplway, dcache_transducer_l15_address,
               dcache_transducer_l15_req_ack,
        output dcache_l15_transducer_header_ack, dcache_l15_transducer_val,
               dcache_l15_transducer_returntype, dcache_l15_transducer_error,
               dcache_l15_transducer_data_0
    );
endinterface

// File: rtl/mor1kx_dcache_l15_transducer.sv
// mor1kx data port to L1.5 transducer, single outstanding request.
// Define MOR1KX_L15_ENDIAN_SWAP_EN to byte-swap data and mirror the bsel-to-offset mapping.
module mor1kx_dcache_l15_transducer #(
    parameter logic [7:0]  ADDR_HI = 8'h00,
    parameter int unsigned NC_BIT  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_adr_i,
    input  logic [31:0] cpu_dat_i,
    input  logic [3:0]  cpu_bsel_i,
    output logic        cpu_ack_o,
    output logic        cpu_err_o,
    output logic [31:0] cpu_dat_o,
    mor1kx_dcache_l15_transducer_if.master l15
);

    localparam logic [4:0] LoadRq    = 5'b00000;
    localparam logic [4:0] StoreRq   = 5'b00001;
    localparam logic [3:0] LoadRet   = 4'b0000;
    localparam logic [3:0] StAck     = 4'b0100;
    localparam logic [2:0] Size1B    = 3'b001;
    localparam logic [2:0] Size2B    = 3'b010;
    localparam logic [2:0] Size4B    = 3'b011;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:2] adr_q, adr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [3:0]  bsel_n;
    logic        dec_ok;
    logic [2:0]  dec_size;
    logic [1:0]  dec_off;
    logic [31:0] st_word;
    logic [31:0] ld_sel;
    logic [31:0] ld_word;
    logic        rsp_match;

`ifdef MOR1KX_L15_ENDIAN_SWAP_EN
    assign bsel_n  = {cpu_bsel_i[0], cpu_bsel_i[1], cpu_bsel_i[2], cpu_bsel_i[3]};
    assign st_word = {cpu_dat_i[7:0], cpu_dat_i[15:8], cpu_dat_i[23:16], cpu_dat_i[31:24]};
    assign ld_word = {ld_sel[7:0], ld_sel[15:8], ld_sel[23:16], ld_sel[31:24]};
`else
    assign bsel_n  = cpu_bsel_i;
    assign st_word = cpu_dat_i;
    assign ld_word = ld_sel;
`endif

    assign ld_sel = adr_q[2] ? l15.dcache_l15_transducer_data_0[31:0]
                             : l15.dcache_l15_transducer_data_0[63:32];

    // bsel_n bit3 always denotes byte offset 0 after the optional mirror
    always_comb begin
        dec_ok   = 1'b1;
        dec_size = Size4B;
        dec_off  = 2'b00;
        case (bsel_n)
            4'b1111: begin dec_size = Size4B; dec_off = 2'b00; end
            4'b1100: begin dec_size = Size2B; dec_off = 2'b00; end
            4'b0011: begin dec_size = Size2B; dec_off = 2'b10; end
            4'b1000: begin dec_size = Size1B; dec_off = 2'b00; end
            4'b0100: begin dec_size = Size1B; dec_off = 2'b01; end
            4'b0010: begin dec_size = Size1B; dec_off = 2'b10; end
            4'b0001: begin dec_size = Size1B; dec_off = 2'b11; end
            default: dec_ok = 1'b0;
        endcase
    end

    assign rsp_match = (l15.dcache_l15_transducer_returntype == LoadRet && !we_q) ||
                       (l15.dcache_l15_transducer_returntype == StAck && we_q);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        off_d   = off_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_req_i) begin
                    we_d    = cpu_we_i;
                    adr_d   = cpu_adr_i[31:2];
                    wdata_d = st_word;
                    size_d  = dec_size;
                    off_d   = dec_off;
                    err_d   = !dec_ok;
                    state_d = dec_ok ? StReq : StDone;
                end
            end
            StReq: begin
                if (l15.dcache_l15_transducer_header_ack) state_d = StWait;
            end
            StWait: begin
                // Evictions and unexpected types are acked and dropped
                if (l15.dcache_l15_transducer_val && rsp_match) begin
                    rdata_d = ld_word;
                    err_d   = |l15.dcache_l15_transducer_error;
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            off_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            off_q   <= off_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    logic req_val;
    assign req_val = (state_q == StReq);

    assign l15.dcache_transducer_l15_val      = req_val;
    assign l15.dcache_transducer_l15_rqtype   = req_val ? (we_q ? StoreRq : LoadRq) : 5'd0;
    assign l15.dcache_transducer_l15_amo_op   = 4'd0;
    assign l15.dcache_transducer_l15_data     = req_val ? {wdata_q, wdata_q} : 64'd0;
    assign l15.dcache_transducer_l15_size     = req_val ? size_q : 3'd0;
    assign l15.dcache_transducer_l15_nc       = req_val & adr_q[NC_BIT];
    assign l15.dcache_transducer_l15_l1rplway = 2'd0;
    assign l15.dcache_transducer_l15_address  = req_val ? {ADDR_HI, adr_q, off_q} : 40'd0;
    // Late responses arriving in IDLE are still consumed
    assign l15.dcache_transducer_l15_req_ack  = l15.dcache_l15_transducer_val && !rst &&
                                                (state_q == StIdle || state_q == StWait);

    assign cpu_ack_o = (state_q == StDone) && !err_q;
    assign cpu_err_o = (state_q == StDone) && err_q;
    assign cpu_dat_o = cpu_ack_o ? rdata_q : 32'd0;

endmodule

// File: tb/tb_mor1kx_dcache_l15_transducer.sv
// Directed self-checking bench for mor1kx_dcache_l15_transducer (default build, no endian swap).
module tb_mor1kx_dcache_l15_transducer;

    localparam logic [4:0] LOAD_RQ   = 5'b00000;
    localparam logic [4:0] STORE_RQ  = 5'b00001;
    localparam logic [3:0] LOAD_RET  = 4'b0000;
    localparam logic [3:0] EVICT_REQ = 4'b0011;
    localparam logic [3:0] ST_ACK    = 4'b0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_i, cpu_we_i;
    logic [31:0] cpu_adr_i, cpu_dat_i;
    logic [3:0]  cpu_bsel_i;
    logic        cpu_ack_o, cpu_err_o;
    logic [31:0] cpu_dat_o;

    int n_checks = 0;
    int n_fail   = 0;

    mor1kx_dcache_l15_transducer_if l15 ();

    mor1kx_dcache_l15_transducer dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req_i  (cpu_req_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_adr_i  (cpu_adr_i),
        .cpu_dat_i  (cpu_dat_i),
        .cpu_bsel_i (cpu_bsel_i),
        .cpu_ack_o  (cpu_ack_o),
        .cpu_err_o  (cpu_err_o),
        .cpu_dat_o  (cpu_dat_o),
        .l15        (l15.master)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " val"},      {63'd0, l15.dcache_transducer_l15_val}, 64'd0);
        check_eq({tag, " address"},  {24'd0, l15.dcache_transducer_l15_address}, 64'd0);
        check_eq({tag, " data"},     l15.dcache_transducer_l15_data, 64'd0);
        check_eq({tag, " req_ack"},  {63'd0, l15.dcache_transducer_l15_req_ack}, 64'd0);
        check_eq({tag, " cpu_ack"},  {63'd0, cpu_ack_o}, 64'd0);
        check_eq({tag, " cpu_err"},  {63'd0, cpu_err_o}, 64'd0);
        check_eq({tag, " cpu_dat"},  {32'd0, cpu_dat_o}, 64'd0);
    endtask

    // Presents one request for a single cycle; returns at the first REQ-state negedge
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] bsel);
        cpu_req_i  = 1'b1;
        cpu_we_i   = we;
        cpu_adr_i  = adr;
        cpu_dat_i  = dat;
        cpu_bsel_i = bsel;
        tick();
        check_eq("no ack in accept cycle", {63'd0, cpu_ack_o}, 64'd0);
        cpu_req_i  = 1'b0;
    endtask

    task automatic accept_header();
        l15.dcache_l15_transducer_header_ack = 1'b1;
        tick();
        l15.dcache_l15_transducer_header_ack = 1'b0;
        check_eq("val drops after header_ack", {63'd0, l15.dcache_transducer_l15_val}, 64'd0);
    endtask

    task automatic respond(input logic [3:0] rtype, input logic [63:0] data,
                           input logic [1:0] err);
        l15.dcache_l15_transducer_val        = 1'b1;
        l15.dcache_l15_transducer_returntype = rtype;
        l15.dcache_l15_transducer_data_0     = data;
        l15.dcache_l15_transducer_error      = err;
        #1;
        check_eq("req_ack with response", {63'd0, l15.dcache_transducer_l15_req_ack}, 64'd1);
        tick();
        l15.dcache_l15_transducer_val   = 1'b0;
        l15.dcache_l15_transducer_error = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_adr_i = '0; cpu_dat_i = '0; cpu_bsel_i = '0;
        l15.dcache_l15_transducer_header_ack = 1'b0;
        l15.dcache_l15_transducer_val        = 1'b0;
        l15.dcache_l15_transducer_returntype = 4'd0;
        l15.dcache_l15_transducer_error      = 2'd0;
        l15.dcache_l15_transducer_data_0     = 64'd0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Aligned load, upper word select via adr[2]
        issue(1'b0, 32'h0000_1004, 32'd0, 4'b1111);
        check_eq("ld val",     {63'd0, l15.dcache_transducer_l15_val}, 64'd1);
        check_eq("ld address", {24'd0, l15.dcache_transducer_l15_address}, 64'h00_0000_1004);
        check_eq("ld size",    {61'd0, l15.dcache_transducer_l15_size}, 64'd3);
        check_eq("ld rqtype",  {59'd0, l15.dcache_transducer_l15_rqtype}, {59'd0, LOAD_RQ});
        check_eq("ld nc",      {63'd0, l15.dcache_transducer_l15_nc}, 64'd0);
        accept_header();
        respond(LOAD_RET, 64'h11223344_55667788, 2'b00);
        check_eq("ld cpu_ack", {63'd0, cpu_ack_o}, 64'd1);
        check_eq("ld cpu_dat", {32'd0, cpu_dat_o}, 64'h55667788);
        tick();
        check_eq("ld ack one cycle", {63'd0, cpu_ack_o}, 64'd0);

        // Noncacheable halfword store
        issue(1'b1, 32'h8000_0002, 32'hAABB_CCDD, 4'b0011);
        check_eq("st rqtype",   {59'd0, l15.dcache_transducer_l15_rqtype}, {59'd0, STORE_RQ});
        check_eq("st nc",       {63'd0, l15.dcache_transducer_l15_nc}, 64'd1);
        check_eq("st size",     {61'd0, l15.dcache_transducer_l15_size}, 64'd2);
        check_eq("st address",  {24'd0, l15.dcache_transducer_l15_address}, 64'h00_8000_0002);
        check_eq("st data",     l15.dcache_transducer_l15_data, 64'hAABBCCDD_AABBCCDD);
        check_eq("st amo_op",   {60'd0, l15.dcache_transducer_l15_amo_op}, 64'd0);
        check_eq("st l1rplway", {62'd0, l15.dcache_transducer_l15_l1rplway}, 64'd0);
        accept_header();
        respond(ST_ACK, 64'd0, 2'b00);
        check_eq("st cpu_ack", {63'd0, cpu_ack_o}, 64'd1);
        check_eq("st cpu_err", {63'd0, cpu_err_o}, 64'd0);
        tick();

        // header_ack withheld for 5 cycles; byte load at offset 0
        issue(1'b0, 32'h0000_2000, 32'd0, 4'b1000);
        for (int i = 0; i < 5; i++) begin
            check_eq("hold val",     {63'd0, l15.dcache_transducer_l15_val}, 64'd1);
            check_eq("hold address", {24'd0, l15.dcache_transducer_l15_address}, 64'h00_0000_2000);
            check_eq("hold size",    {61'd0, l15.dcache_transducer_l15_size}, 64'd1);
            tick();
        end
        check_eq("hold val at header_ack", {63'd0, l15.dcache_transducer_l15_val}, 64'd1);
        accept_header();
        respond(LOAD_RET, 64'hDEADBEEF_01234567, 2'b00);
        check_eq("hold cpu_dat", {32'd0, cpu_dat_o}, 64'hDEADBEEF);
        tick();

        // Eviction before the load return
        issue(1'b0, 32'h0000_3000, 32'd0, 4'b0001);
        check_eq("ev address", {24'd0, l15.dcache_transducer_l15_address}, 64'h00_0000_3003);
        accept_header();
        respond(EVICT_REQ, 64'hFFFFFFFF_FFFFFFFF, 2'b00);
        check_eq("ev no cpu_ack", {63'd0, cpu_ack_o}, 64'd0);
        respond(LOAD_RET, 64'hCAFEF00D_12345678, 2'b00);
        check_eq("ev cpu_ack", {63'd0, cpu_ack_o}, 64'd1);
        check_eq("ev cpu_dat", {32'd0, cpu_dat_o}, 64'hCAFEF00D);
        tick();
        check_eq("ev single ack", {63'd0, cpu_ack_o}, 64'd0);

        // Response error
        issue(1'b1, 32'h0000_0040, 32'h1234_5678, 4'b1111);
        accept_header();
        respond(ST_ACK, 64'd0, 2'b01);
        check_eq("rsp err", {63'd0, cpu_err_o}, 64'd1);
        check_eq("rsp err no ack", {63'd0, cpu_ack_o}, 64'd0);
        tick();
        check_eq("rsp err one cycle", {63'd0, cpu_err_o}, 64'd0);

        // Illegal bsel: no L1.5 request, error straight away
        issue(1'b0, 32'h0000_0050, 32'd0, 4'b0110);
        check_eq("bad bsel no val", {63'd0, l15.dcache_transducer_l15_val}, 64'd0);
        check_eq("bad bsel err",    {63'd0, cpu_err_o}, 64'd1);
        check_eq("bad bsel no ack", {63'd0, cpu_ack_o}, 64'd0);
        tick();
        check_eq("bad bsel after", {63'd0, cpu_err_o | l15.dcache_transducer_l15_val}, 64'd0);

        // Reset in WAIT, late response in IDLE, then a normal load
        issue(1'b0, 32'h0000_5004, 32'd0, 4'b1111);
        accept_header();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("rst in wait");
        respond(LOAD_RET, 64'h99999999_88888888, 2'b00);
        check_eq("late rsp no ack", {63'd0, cpu_ack_o}, 64'd0);
        issue(1'b0, 32'h0000_5000, 32'd0, 4'b1100);
        check_eq("post rst address", {24'd0, l15.dcache_transducer_l15_address}, 64'h00_0000_5000);
        check_eq("post rst size",    {61'd0, l15.dcache_transducer_l15_size}, 64'd2);
        accept_header();
        respond(LOAD_RET, 64'h0BADF00D_77777777, 2'b00);
        check_eq("post rst ack", {63'd0, cpu_ack_o}, 64'd1);
        check_eq("post rst dat", {32'd0, cpu_dat_o}, 64'h0BADF00D);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
